// File: rtl/traffic_mode_arbiter_if.sv
// Handshake and status bundle between traffic_mode_arbiter and its neighbours.
// slave: arbiter side; master: sensor conditioning plus light sequencer side.
interface traffic_mode_arbiter_if #(
    parameter int NUM_PED = 2
);
    logic               time_sig;
    logic [NUM_PED-1:0] ped_press;
    logic               emg_sig;
    logic               mode_ack;
    logic [1:0]         mode;
    logic [1:0]         next_mode;
    logic               mode_req;
    logic               ped_waiting;
    logic [NUM_PED-1:0] ped_served;
    logic               dwell_done;

    modport slave (
        input  time_sig, ped_press, emg_sig, mode_ack,
        output mode, next_mode, mode_req,
        output ped_waiting, ped_served, dwell_done
    );

    modport master (
        output time_sig, ped_press, emg_sig, mode_ack,
        input  mode, next_mode, mode_req,
        input  ped_waiting, ped_served, dwell_done
    );
endinterface

// File: rtl/traffic_mode_arbiter.sv
// Four-mode traffic arbiter: day/night/ped/emergency with dwell, emergency hold
// and req/ack commit. Optional macro TRAFFIC_MODE_DEBOUNCE_EN filters time_sig.
module traffic_mode_arbiter #(
    parameter int NUM_PED    = 2,
    parameter int CNT_W      = 8,
    parameter int MIN_DWELL  = 16,
    parameter int EMG_HOLD   = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_mode_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(EMG_HOLD);

    typedef enum logic {ST_STABLE, ST_REQ} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         next_q, next_d;
    logic               req_q, req_d;
    logic [NUM_PED-1:0] latch_q, latch_d;
    logic [NUM_PED-1:0] served_q, served_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               time_sel;
    logic               dwell_done;
    logic               commit;
    logic [1:0]         target;

`ifdef TRAFFIC_MODE_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          filt_q, filt_d;
    logic [DW-1:0] deb_q, deb_d;

    // Filtered time_sig flips after DEB_CYCLES consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        deb_d  = '0;
        if (bus.time_sig != filt_q) begin
            if (deb_q == DEB_LAST) begin
                filt_d = bus.time_sig;
            end else begin
                deb_d = deb_q + DW'(1);
            end
        end
    end

    // Debounce state; powers up assuming day
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            deb_q  <= '0;
        end else begin
            filt_q <= filt_d;
            deb_q  <= deb_d;
        end
    end

    assign time_sel = filt_q;
`else
    logic unused_deb;
    assign unused_deb = (DEB_CYCLES == 0);
    assign time_sel   = bus.time_sig;
`endif

    assign dwell_done = (dwell_q == DWELL_MAX);
    assign commit     = (state_q == ST_REQ) && bus.mode_ack;

    // Desired mode: emergency, then pedestrians, then time of day
    always_comb begin
        target = 2'b01;
        if (bus.emg_sig || (hold_q != '0)) begin
            target = 2'b11;
        end else if (|latch_q) begin
            target = 2'b10;
        end else if (time_sel) begin
            target = 2'b00;
        end
    end

    // Latches, counters and request/commit sequencing
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        next_d   = next_q;
        req_d    = req_q;
        served_d = '0;
        latch_d  = latch_q | bus.ped_press;

        if (bus.emg_sig) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - CNT_W'(1);
        end else begin
            hold_d = '0;
        end

        if (commit) begin
            dwell_d = '0;
        end else if (!dwell_done) begin
            dwell_d = dwell_q + CNT_W'(1);
        end else begin
            dwell_d = dwell_q;
        end

        // A press landing in the serving cycle survives the clear
        if (commit && (next_q == 2'b10)) begin
            served_d = latch_q;
            latch_d  = bus.ped_press;
        end

        if (state_q == ST_STABLE) begin
            if ((target != mode_q) &&
                (dwell_done || (target == 2'b11))) begin
                next_d  = target;
                req_d   = 1'b1;
                state_d = ST_REQ;
            end
        end else begin
            if (bus.mode_ack) begin
                mode_d  = next_q;
                req_d   = 1'b0;
                state_d = ST_STABLE;
            end else if ((target == 2'b11) && (next_q != 2'b11)) begin
                next_d = 2'b11;
            end
        end
    end

    // Register all state; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_STABLE;
            mode_q   <= 2'b00;
            next_q   <= 2'b00;
            req_q    <= 1'b0;
            latch_q  <= '0;
            served_q <= '0;
            dwell_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            next_q   <= next_d;
            req_q    <= req_d;
            latch_q  <= latch_d;
            served_q <= served_d;
            dwell_q  <= dwell_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.next_mode   = next_q;
    assign bus.mode_req    = req_q;
    assign bus.ped_waiting = |latch_q;
    assign bus.ped_served  = served_q;
    assign bus.dwell_done  = dwell_done;
endmodule

// File: tb/tb_traffic_mode_arbiter.sv
// Directed plus randomized bench for traffic_mode_arbiter with a
// cycle-level behavioural model of the mode rules.
module tb_traffic_mode_arbiter;
    localparam int NUM_PED    = 2;
    localparam int MIN_DWELL  = 16;
    localparam int EMG_HOLD   = 8;
    localparam int DEB_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;

    traffic_mode_arbiter_if #(.NUM_PED(NUM_PED)) bus ();

    traffic_mode_arbiter #(
        .NUM_PED(NUM_PED), .CNT_W(8), .MIN_DWELL(MIN_DWELL),
        .EMG_HOLD(EMG_HOLD), .DEB_CYCLES(DEB_CYCLES)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state (plain integers and bit vectors)
    logic [1:0]         m_mode, m_next;
    bit                 m_req;
    bit [NUM_PED-1:0]   m_peds, m_served;
    int                 m_dwell, m_hold, m_deb;
    bit                 m_filt;

    task automatic m_reset();
        m_mode = 2'b00; m_next = 2'b00; m_req = 1'b0;
        m_peds = '0; m_served = '0;
        m_dwell = 0; m_hold = 0; m_deb = 0; m_filt = 1'b1;
    endtask

    task automatic model_step();
        logic [1:0]       tgt;
        bit               tsel, commit;
        bit [NUM_PED-1:0] n_peds, n_served;
        int               n_dwell, n_hold;
`ifdef TRAFFIC_MODE_DEBOUNCE_EN
        tsel = m_filt;
        if (bus.time_sig != m_filt) begin
            m_deb++;
            if (m_deb == DEB_CYCLES) begin
                m_filt = bus.time_sig; m_deb = 0;
            end
        end else begin
            m_deb = 0;
        end
`else
        tsel = bus.time_sig;
`endif
        if (bus.emg_sig || m_hold > 0) tgt = 2'd3;
        else if (m_peds != 0)          tgt = 2'd2;
        else if (tsel)                 tgt = 2'd0;
        else                           tgt = 2'd1;
        commit = m_req && bus.mode_ack;
        if (commit && m_next == 2'd2) begin
            n_served = m_peds; n_peds = bus.ped_press;
        end else begin
            n_served = '0; n_peds = m_peds | bus.ped_press;
        end
        n_hold  = bus.emg_sig ? EMG_HOLD : (m_hold > 0 ? m_hold - 1 : 0);
        n_dwell = commit ? 0 :
                  (m_dwell + 1 > MIN_DWELL ? MIN_DWELL : m_dwell + 1);
        if (!m_req) begin
            if (tgt != m_mode && (m_dwell >= MIN_DWELL || tgt == 2'd3)) begin
                m_next = tgt; m_req = 1'b1;
            end
        end else if (commit) begin
            m_mode = m_next; m_req = 1'b0;
        end else if (tgt == 2'd3) begin
            m_next = 2'd3;
        end
        m_peds = n_peds; m_served = n_served;
        m_dwell = n_dwell; m_hold = n_hold;
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        check("mode", 8'(bus.mode), 8'(m_mode));
        check("mode_req", 8'(bus.mode_req), 8'(m_req));
        if (m_req) check("next_mode", 8'(bus.next_mode), 8'(m_next));
        check("ped_waiting", 8'(bus.ped_waiting), 8'(m_peds != 0));
        check("ped_served", 8'(bus.ped_served), 8'(m_served));
        check("dwell_done", 8'(bus.dwell_done), 8'(m_dwell == MIN_DWELL));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step(); else m_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_req(string tag, int bound);
        int n = 0;
        while (!m_req && n < bound) begin
            cycle(); n++;
        end
        check(tag, 8'(bus.mode_req), 8'd1);
    endtask

    task automatic ack_once();
        bus.mode_ack = 1'b1; cycle(); bus.mode_ack = 1'b0;
    endtask

    initial begin
        bus.time_sig = 1'b1; bus.ped_press = '0;
        bus.emg_sig = 1'b0; bus.mode_ack = 1'b0;
        m_reset();
        #1;
        check("rst_mode", 8'(bus.mode), 8'd0);
        check("rst_req", 8'(bus.mode_req), 8'd0);
        check("rst_served", 8'(bus.ped_served), 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // Day held, then night requested and committed
        cycles(40);
        check("s1_day_mode", 8'(bus.mode), 8'd0);
        check("s1_no_req", 8'(bus.mode_req), 8'd0);
        bus.time_sig = 1'b0; cycle();
        check("s1_req", 8'(bus.mode_req), 8'd1);
        check("s1_next", 8'(bus.next_mode), 8'd1);
        cycles(3);
        ack_once();
        check("s1_mode_night", 8'(bus.mode), 8'd1);
        check("s1_dwell_clr", 8'(bus.dwell_done), 8'd0);

        // Back to day, then pedestrian service with a commit-cycle press
        bus.time_sig = 1'b1;
        wait_req("s2_day_req", 30);
        ack_once();
        check("s2_mode_day", 8'(bus.mode), 8'd0);
        cycles(3);
        bus.ped_press = 2'b10; cycle(); bus.ped_press = '0;
        check("s2_waiting", 8'(bus.ped_waiting), 8'd1);
        check("s2_no_early_req", 8'(bus.mode_req), 8'd0);
        wait_req("s2_ped_req", 30);
        check("s2_next_ped", 8'(bus.next_mode), 8'd2);
        bus.ped_press = 2'b01; bus.mode_ack = 1'b1;
        cycle();
        bus.ped_press = '0; bus.mode_ack = 1'b0;
        check("s2_mode_ped", 8'(bus.mode), 8'd2);
        check("s2_served", 8'(bus.ped_served), 8'h2);
        check("s2_relatched", 8'(bus.ped_waiting), 8'd1);
        cycle();
        check("s2_served_pulse", 8'(bus.ped_served), 8'h0);

        // Emergency bypasses dwell, then hold-off before leaving
        bus.time_sig = 1'b0; cycles(2);
        bus.emg_sig = 1'b1; cycle();
        check("s3_emg_req", 8'(bus.mode_req), 8'd1);
        check("s3_emg_next", 8'(bus.next_mode), 8'd3);
        check("s3_dwell_low", 8'(bus.dwell_done), 8'd0);
        ack_once();
        check("s3_mode_emg", 8'(bus.mode), 8'd3);
        bus.emg_sig = 1'b0;
        for (int i = 0; i < EMG_HOLD; i++) begin
            cycle();
            check("s3_hold", 8'(bus.mode_req), 8'd0);
        end
        wait_req("s3_leave_req", 30);
        check("s3_leave_next", 8'(bus.next_mode), 8'd2);

        // Upgrade while pending, then ack coincident with upgrade
        bus.emg_sig = 1'b1; cycle();
        check("s4_upgrade", 8'(bus.next_mode), 8'd3);
        check("s4_req_held", 8'(bus.mode_req), 8'd1);
        ack_once();
        bus.emg_sig = 1'b0;
        check("s4_mode_emg", 8'(bus.mode), 8'd3);
        wait_req("s4_ped_req", 40);
        check("s4_next_ped", 8'(bus.next_mode), 8'd2);
        bus.emg_sig = 1'b1;
        ack_once();
        check("s4_commit_ped", 8'(bus.mode), 8'd2);
        check("s4_served", 8'(bus.ped_served), 8'h1);
        cycle();
        check("s4_rereq", 8'(bus.mode_req), 8'd1);
        check("s4_rereq_next", 8'(bus.next_mode), 8'd3);
        ack_once();
        bus.emg_sig = 1'b0;

        // Asynchronous reset in the middle of a request
        wait_req("s5_night_req", 40);
        ack_once();
        check("s5_mode_night", 8'(bus.mode), 8'd1);
        bus.time_sig = 1'b1;
        wait_req("s5_day_req", 30);
        bus.ped_press = 2'b11; cycle(); bus.ped_press = '0;
        check("s5_waiting", 8'(bus.ped_waiting), 8'd1);
        #2 rst = 1'b0;
        #1;
        check("s5_async_mode", 8'(bus.mode), 8'd0);
        check("s5_async_req", 8'(bus.mode_req), 8'd0);
        check("s5_async_ped", 8'(bus.ped_waiting), 8'd0);
        m_reset();
        cycle();
        rst = 1'b1;

        // Short time_sig glitch once dwell is done
        cycles(20);
`ifdef TRAFFIC_MODE_DEBOUNCE_EN
        bus.time_sig = 1'b0; cycles(3); bus.time_sig = 1'b1; cycle();
        check("s6_glitch_filtered", 8'(bus.mode_req), 8'd0);
        bus.time_sig = 1'b0; cycles(4); cycle();
        check("s6_deb_req", 8'(bus.mode_req), 8'd1);
        check("s6_deb_next", 8'(bus.next_mode), 8'd1);
`else
        bus.time_sig = 1'b0; cycle(); bus.time_sig = 1'b1;
        check("s6_glitch_req", 8'(bus.mode_req), 8'd1);
        check("s6_glitch_next", 8'(bus.next_mode), 8'd1);
`endif
        ack_once();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.emg_sig = ~bus.emg_sig;
            if ($urandom_range(0, 29) == 0) bus.time_sig = ~bus.time_sig;
            bus.ped_press = ($urandom_range(0, 19) == 0) ?
                            NUM_PED'($urandom) : '0;
            bus.mode_ack = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
